// File: rtl/falling_square_controller.sv
// Per-frame erase/advance/redraw sequencer for one falling square sprite on a
// 160x120 framebuffer. Emits one pixel per cycle on x/y/colour/plot.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | after reset, waiting for go
// DRAW      | scanning sprite pixels in COLOUR at (pos_x, pos_y)
// WAIT_TICK | sprite on screen, waiting for the next frame tick
// ERASE     | scanning sprite pixels in BG at the old position
// UPDATE    | one cycle: advance pos_y by STEP, saturating at the landing row
// LANDED    | sprite rests on the bottom rows, waiting for go to restart
module falling_square_controller #(
  parameter int         SIZE   = 4,
  parameter int         STEP   = 1,
  parameter logic [2:0] COLOUR = 3'b110,
  parameter logic [2:0] BG     = 3'b000,
  parameter int         X_MAX  = 159,
  parameter int         Y_MAX  = 119
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] x_start,
  input  logic       tick,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       landed
);

  localparam logic [7:0] X_LIM    = 8'(X_MAX + 1 - SIZE);
  localparam logic [7:0] Y_LAND8  = 8'(Y_MAX + 1 - SIZE);
  localparam logic [6:0] Y_LAND   = Y_LAND8[6:0];
  localparam logic [7:0] STEP8    = 8'(STEP);
  localparam logic [2:0] LAST_IDX = 3'(SIZE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAW      = 3'd1,
    WAIT_TICK = 3'd2,
    ERASE     = 3'd3,
    UPDATE    = 3'd4,
    LANDED    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pos_x_q, pos_x_d;
  logic [6:0] pos_y_q, pos_y_d;
  logic [2:0] dx_q, dx_d;
  logic [2:0] dy_q, dy_d;

  logic       last_col;
  logic       last_px;
  logic [7:0] x_clamped;
  logic [7:0] y_sum;
  logic [6:0] y_next;

  assign last_col  = (dx_q == LAST_IDX);
  assign last_px   = last_col && (dy_q == LAST_IDX);
  assign x_clamped = (x_start > X_LIM) ? X_LIM : x_start;
  // Eight bits wide so a large STEP near the bottom cannot wrap past zero.
  assign y_sum     = {1'b0, pos_y_q} + STEP8;
  assign y_next    = (y_sum > Y_LAND8) ? Y_LAND : y_sum[6:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;

    unique case (state_q)
      IDLE, LANDED: begin
        if (go) begin
          pos_x_d = x_clamped;
          pos_y_d = '0;
          dx_d    = '0;
          dy_d    = '0;
          state_d = DRAW;
        end
      end

      DRAW, ERASE: begin
        if (last_px) begin
          dx_d = '0;
          dy_d = '0;
          if (state_q == ERASE)        state_d = UPDATE;
          else if (pos_y_q == Y_LAND)  state_d = LANDED;
          else                         state_d = WAIT_TICK;
        end else if (last_col) begin
          dx_d = '0;
          dy_d = dy_q + 3'd1;
        end else begin
          dx_d = dx_q + 3'd1;
        end
      end

      WAIT_TICK: begin
        if (tick) state_d = ERASE;
      end

      UPDATE: begin
        pos_y_d = y_next;
        state_d = DRAW;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x      = '0;
    y      = '0;
    colour = '0;
    plot   = 1'b0;
    if (state_q == DRAW || state_q == ERASE) begin
      plot   = 1'b1;
      x      = pos_x_q + {5'b0, dx_q};
      y      = pos_y_q + {4'b0, dy_q};
      colour = (state_q == DRAW) ? COLOUR : BG;
    end
  end

  assign busy   = (state_q == DRAW) || (state_q == ERASE) || (state_q == UPDATE);
  assign landed = (state_q == LANDED);

endmodule

// File: doc/falling_square_controller.md
# falling_square_controller

Sequences per-frame redraw of one falling square sprite on the 160x120 VGA framebuffer. Consumes the one-cycle frame-rate `tick` from the frame delay counter and, on each tick, erases the sprite, advances its position, and redraws it. Drives the VGA adapter's `x`/`y`/`colour`/`plot` port. Stops when the sprite reaches the bottom row.

## Interface
- `SIZE`, default 4: sprite side in pixels (1..8).
- `STEP`, default 1: rows moved down per tick (1..8).
- `COLOUR`, default 3'b110: sprite colour.
- `BG`, default 3'b000: erase colour.
- `X_MAX`, default 159: last column.
- `Y_MAX`, default 119: last row.
- `clock  in  1`: system clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-low.
- `go  in  1`: start or restart a drop; honoured only in IDLE or LANDED.
- `x_start  in  8`: sprite left column, sampled on an accepted `go`.
- `tick  in  1`: one-cycle frame pulse from the delay counter.
- `x  out  8`: pixel column.
- `y  out  7`: pixel row.
- `colour  out  3`: pixel colour.
- `plot  out  1`: pixel write enable, one pixel per cycle.
- `busy  out  1`: high in ERASE, UPDATE and DRAW.
- `landed  out  1`: high in LANDED.

## Operation
- Registers: `state`, `pos_x[7:0]`, `pos_y[6:0]`, `dx`, `dy` (each 3 bits), plus the FSM.
- `X_LIM = X_MAX+1-SIZE` (156). `Y_LAND = Y_MAX+1-SIZE` (116).
- States and transitions:
  - IDLE: reset state. On `go`: `pos_x <= min(x_start, X_LIM)`, `pos_y <= 0`, `dx,dy <= 0`; go to DRAW.
  - DRAW: scans the sprite pixels.
    - `dx` increments each cycle and wraps at SIZE-1. On wrap, `dy` increments.
    - On the pixel with `dx=dy=SIZE-1`: clear the counters. Go to LANDED if `pos_y==Y_LAND`, else WAIT_TICK.
  - WAIT_TICK: on `tick`, go to ERASE.
  - ERASE: same scan as DRAW. Go to UPDATE after the last pixel.
  - UPDATE: one cycle. `pos_y <= min(pos_y+STEP, Y_LAND)`, computed 8 bits wide so it cannot wrap. Then go to DRAW.
  - LANDED: on `go`, take the same action as in IDLE.
- Outputs are combinational from the registers (Moore):
  - `plot=1` only in DRAW and ERASE.
  - In DRAW/ERASE: `x=pos_x+dx`, `y=pos_y+dy`.
  - `colour` is COLOUR in DRAW and BG in ERASE.
  - All other states: `x=0`, `y=0`, `colour=0`.
- `tick` is acted on only in WAIT_TICK. Ticks in any other state are dropped, not queued.
- `go` is ignored outside IDLE and LANDED.
- `x_start` is read only on an accepted `go`.
- Drawn pixels never exceed `X_MAX`/`Y_MAX`, because of the clamps on `pos_x` and `pos_y`.

## Timing
- Reset (`reset=0` at an edge, in any state, mid-scan included):
  - Next cycle: state IDLE, `pos_x=pos_y=dx=dy=0`.
  - Outputs: `plot=0`, `x=0`, `y=0`, `colour=0`, `busy=0`, `landed=0`.
  - Reset wins over a simultaneous `go` or `tick`.
- `go` sampled at edge E: first DRAW pixel (`plot=1`) is in the cycle after E. `plot` stays high for exactly SIZE² consecutive cycles.
- Row-major pixel order: (pos_x,pos_y), (pos_x+1,pos_y), … (pos_x+SIZE-1,pos_y+SIZE-1).
- `tick` sampled at edge T in WAIT_TICK:
  - SIZE² erase cycles, then 1 UPDATE cycle (`plot=0`, `busy=1`), then SIZE² draw cycles.
  - Total busy: 2·SIZE²+1 cycles (33 at SIZE=4), far below one frame.
- LANDED is entered on the edge after the last DRAW pixel at `pos_y==Y_LAND`.
- A `go` in LANDED restarts with a DRAW at row 0. The old sprite is not erased.

## Test plan
- Reset: hold `reset=0` 2 cycles with `go=1` and `tick=1` -> `plot=0`, `busy=0`, `landed=0`, `x=y=colour=0`, state IDLE.
- Initial draw: `go` with `x_start=10` -> 16 plot cycles covering x 10..13, y 0..3 row-major, `colour=6`; then `plot=0`, `busy=0`.
- One tick: `tick` pulse -> 16 cycles with `colour=0` at y 0..3, 1 idle busy cycle, then 16 cycles with `colour=6` at y 1..4, x 10..13.
- Clamp and ignore: `go` with `x_start=200` -> columns 156..159. A `tick` during DRAW and a `go` during ERASE -> no extra frame, no restart, positions unchanged.
- Landing with `STEP=3`:
  - 39 ticks -> `pos_y` saturates at 116 (117 cycles of 3 truncated), `landed=1`, last draw at y 116..119.
  - A further `tick` -> no `plot`.
  - `go` -> redraw at y 0.
- Reset mid-ERASE: `reset=0` on the 5th erase pixel -> `plot=0` the next cycle, `busy=0`, and the next `go` draws at y 0.
